// File: rtl/utmi_tx_pkg.sv
// Shared encodings for the UTMI transmit path: stuffing modes, SYNC field,
// line levels and serializer state codes.
package utmi_tx_pkg;

    // bit_stuff_en encodings driven by the TX control FSM
    localparam logic [1:0] NO_OP     = 2'b00;
    localparam logic [1:0] STUFF_OFF = 2'b01;
    localparam logic [1:0] STUFF_ON  = 2'b10;

    localparam logic [7:0] SYNC_PATTERN = 8'h80;

    // Line levels packed as {DP, DM}
    localparam logic [1:0] LINE_J   = 2'b10;
    localparam logic [1:0] LINE_K   = 2'b01;
    localparam logic [1:0] LINE_SE0 = 2'b00;

    localparam int unsigned STATE_W = 3;
    localparam logic [STATE_W-1:0] ST_IDLE    = 3'd0;
    localparam logic [STATE_W-1:0] ST_SYNC    = 3'd1;
    localparam logic [STATE_W-1:0] ST_DATA    = 3'd2;
    localparam logic [STATE_W-1:0] ST_EOP_SE0 = 3'd3;
    localparam logic [STATE_W-1:0] ST_EOP_J   = 3'd4;

    // NRZI: a 0 toggles between J and K, a 1 holds the current level
    function automatic logic [1:0] nrzi_next(input logic [1:0] line, input logic bit_val);
        if (bit_val) begin
            return line;
        end
        return (line == LINE_J) ? LINE_K : LINE_J;
    endfunction

endpackage

// File: rtl/utmi_tx_bit_timer.sv
// Edge counter that marks the last Clk of every USB bit time.
module utmi_tx_bit_timer
    import utmi_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4
) (
    input  logic Clk,
    input  logic Rst,
    input  logic edge_cnt_enable,
    output logic bit_tick_c
);

    localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);

    logic [CNT_W-1:0] cnt_q;

    // Free-running 0..CLKS_PER_BIT-1 counter, held at zero while disabled
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            cnt_q <= '0;
        end else if (!edge_cnt_enable || (cnt_q == CNT_LAST)) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CNT_W'(1);
        end
    end

    assign bit_tick_c = edge_cnt_enable & (cnt_q == CNT_LAST);

endmodule

// File: rtl/utmi_tx_serializer.sv
// Bit-level UTMI transmit datapath: hold/shift registers, bit stuffing,
// NRZI encoding and SYNC/EOP line signalling.
module utmi_tx_serializer
    import utmi_tx_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = 4,
    parameter int unsigned STUFF_LIMIT  = 6
) (
    input  logic       Clk,
    input  logic       Rst,
    input  logic       TX_Valid,
    input  logic [7:0] DataIn,
    input  logic       sync_enable,
    input  logic       load_data_enable,
    input  logic [1:0] bit_stuff_en,
    input  logic       edge_cnt_enable,
    input  logic       EOP_enable,
    output logic       sync_done,
    output logic       TX_hold_empty,
    output logic       EOP_done,
    output logic       DP_out,
    output logic       DM_out,
    output logic       TX_OE
);

    localparam int unsigned ONES_W = $clog2(STUFF_LIMIT + 1);
    localparam logic [ONES_W-1:0] ONES_MAX = ONES_W'(STUFF_LIMIT);
    localparam int unsigned IDX_W = 4;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(7);

    logic [STATE_W-1:0] state_q, state_nxt;
    logic [7:0]         shift_q, shift_nxt;
    logic [IDX_W-1:0]   idx_q, idx_nxt;
    logic [7:0]         hold_q, hold_nxt;
    logic               hold_empty_q, hold_empty_nxt;
    logic [1:0]         line_q, line_nxt;
    logic               oe_q, oe_nxt;
    logic               sync_done_q, sync_done_nxt;
    logic               eop_done_q, eop_done_nxt;
    logic [ONES_W-1:0]  ones_q, ones_nxt;
    logic               se0_cnt_q, se0_cnt_nxt;

    logic bit_tick_c;
    logic load_c;
    logic stuff_c;
    logic exhausted_c;
    logic emit_c;
    logic emit_bit_c;

    utmi_tx_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_bit_timer (
        .Clk            (Clk),
        .Rst            (Rst),
        .edge_cnt_enable(edge_cnt_enable),
        .bit_tick_c     (bit_tick_c)
    );

    assign load_c      = load_data_enable & TX_Valid & hold_empty_q;
    assign stuff_c     = (ones_q == ONES_MAX) && (bit_stuff_en == STUFF_ON);
    assign exhausted_c = idx_q[IDX_W-1];

    // Next-state, datapath and output decode
    always_comb begin
        state_nxt      = state_q;
        shift_nxt      = shift_q;
        idx_nxt        = idx_q;
        hold_nxt       = hold_q;
        hold_empty_nxt = hold_empty_q;
        line_nxt       = line_q;
        oe_nxt         = oe_q;
        sync_done_nxt  = 1'b0;
        eop_done_nxt   = 1'b0;
        ones_nxt       = ones_q;
        se0_cnt_nxt    = se0_cnt_q;
        emit_c         = 1'b0;
        emit_bit_c     = 1'b0;

        if (load_c) begin
            hold_nxt       = DataIn;
            hold_empty_nxt = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                line_nxt = LINE_J;
                oe_nxt   = 1'b0;
                ones_nxt = '0;
                if (sync_enable) begin
                    state_nxt = ST_SYNC;
                    oe_nxt    = 1'b1;
                    shift_nxt = SYNC_PATTERN;
                    idx_nxt   = '0;
                end
            end
            ST_SYNC: begin
                if (bit_tick_c) begin
                    emit_c     = 1'b1;
                    emit_bit_c = shift_q[0];
                    shift_nxt  = {1'b0, shift_q[7:1]};
                    idx_nxt    = idx_q + IDX_W'(1);
                    if (idx_q == IDX_LAST) begin
                        sync_done_nxt = 1'b1;
                        state_nxt     = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (bit_tick_c) begin
                    if (stuff_c) begin
                        emit_c     = 1'b1;
                        emit_bit_c = 1'b0;
                    end else if (!exhausted_c) begin
                        emit_c     = 1'b1;
                        emit_bit_c = shift_q[0];
                        shift_nxt  = {1'b0, shift_q[7:1]};
                        idx_nxt    = idx_q + IDX_W'(1);
                    end else if (!hold_empty_q) begin
                        // Refill and send bit 0 on the same tick so bytes run back to back
                        emit_c     = 1'b1;
                        emit_bit_c = hold_q[0];
                        shift_nxt  = {1'b0, hold_q[7:1]};
                        idx_nxt    = IDX_W'(1);
                        if (!load_c) begin
                            hold_empty_nxt = 1'b1;
                        end
                    end else if (EOP_enable) begin
                        state_nxt   = ST_EOP_SE0;
                        line_nxt    = LINE_SE0;
                        se0_cnt_nxt = 1'b0;
                    end
                end
            end
            ST_EOP_SE0: begin
                if (bit_tick_c) begin
                    if (se0_cnt_q) begin
                        state_nxt = ST_EOP_J;
                        line_nxt  = LINE_J;
                    end else begin
                        se0_cnt_nxt = 1'b1;
                    end
                end
            end
            ST_EOP_J: begin
                if (bit_tick_c) begin
                    eop_done_nxt = 1'b1;
                    oe_nxt       = 1'b0;
                    state_nxt    = ST_IDLE;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                line_nxt  = LINE_J;
                oe_nxt    = 1'b0;
            end
        endcase

        if (emit_c) begin
            line_nxt = nrzi_next(line_q, emit_bit_c);
            if (emit_bit_c && (bit_stuff_en != NO_OP)) begin
                if (ones_q != ONES_MAX) begin
                    ones_nxt = ones_q + ONES_W'(1);
                end
            end else begin
                ones_nxt = '0;
            end
        end

        if (bit_stuff_en == NO_OP) begin
            ones_nxt = '0;
        end
    end

    // State and datapath registers
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q      <= ST_IDLE;
            shift_q      <= '0;
            idx_q        <= '0;
            hold_q       <= '0;
            hold_empty_q <= 1'b1;
            line_q       <= LINE_J;
            oe_q         <= 1'b0;
            sync_done_q  <= 1'b0;
            eop_done_q   <= 1'b0;
            ones_q       <= '0;
            se0_cnt_q    <= 1'b0;
        end else begin
            state_q      <= state_nxt;
            shift_q      <= shift_nxt;
            idx_q        <= idx_nxt;
            hold_q       <= hold_nxt;
            hold_empty_q <= hold_empty_nxt;
            line_q       <= line_nxt;
            oe_q         <= oe_nxt;
            sync_done_q  <= sync_done_nxt;
            eop_done_q   <= eop_done_nxt;
            ones_q       <= ones_nxt;
            se0_cnt_q    <= se0_cnt_nxt;
        end
    end

    assign sync_done     = sync_done_q;
    assign EOP_done      = eop_done_q;
    assign TX_hold_empty = hold_empty_q;
    assign DP_out        = line_q[1];
    assign DM_out        = line_q[0];
    assign TX_OE         = oe_q;

endmodule
